axi_sram_slave: RTL and testbench

- AXI4 responder modelling the main memory that the core's AXI master port talks to. Accepts read bursts on AR/R and write bursts on AW/W/B.
- Backed by an internal word-addressed 64-bit array; serves cache-line refills, write-backs and uncached accesses.
- Used as the memory end in the simulation top, so the core's AXI master port can be exercised without external C models.

---
 rtl/axi_sram_slave.sv | 266 ++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI4 memory responder backed by a 64-bit word array.
// Independent read (AR/R) and write (AW/W/B) burst engines.
module axi_sram_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned WR_LAT     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ar_addr,
    input  logic [3:0]  ar_id,
    input  logic [7:0]  ar_len,
    input  logic [2:0]  ar_size,
    input  logic [1:0]  ar_brust,
    input  logic        ar_valid,
    output logic        ar_ready,
    output logic [63:0] r_data,
    output logic [3:0]  r_id,
    output logic [1:0]  r_resp,
    output logic        r_last,
    output logic        r_valid,
    input  logic        r_ready,
    input  logic [31:0] aw_addr,
    input  logic [3:0]  aw_id,
    input  logic [7:0]  aw_len,
    input  logic [2:0]  aw_size,
    input  logic [1:0]  aw_brust,
    input  logic        aw_valid,
    output logic        aw_ready,
    input  logic [63:0] w_data,
    input  logic [7:0]  w_strb,
    input  logic        w_last,
    input  logic        w_valid,
    output logic        w_ready,
    output logic [3:0]  b_id,
    output logic [1:0]  b_resp,
    output logic        b_valid,
    input  logic        b_ready
);

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;
    localparam int unsigned OFF_W = DEPTH_LOG2 + 3;
    localparam logic [31:0] MEM_BYTES = 32'(64'd8 << DEPTH_LOG2);
    localparam logic [7:0] RLAT_LD = (RD_LAT > 0) ? 8'(RD_LAT - 1) : 8'd0;
    localparam logic [7:0] WLAT_LD = (WR_LAT > 0) ? 8'(WR_LAT - 1) : 8'd0;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {RIDLE, RWAIT, RDATA} rstate_t;
    typedef enum logic [1:0] {WIDLE, WDATA, WWAIT, WRESP} wstate_t;

    function automatic logic [31:0] next_addr(
        input logic [31:0] a,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << size;
        mask = step * (32'(len) + 32'd1) - 32'd1;
        next_addr = a + step;
        if (burst == BURST_FIXED)
            next_addr = a;
        else if (burst == BURST_WRAP)
            next_addr = (a & ~mask) | ((a + step) & mask);
    endfunction

    function automatic logic burst_bad(
        input logic [2:0] size,
        input logic [7:0] len,
        input logic [1:0] burst
    );
        logic wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) ||
                  (len == 8'd7) || (len == 8'd15);
        return (size > 3'd3) || (burst == 2'd3) ||
               ((burst == BURST_WRAP) && !wrap_ok);
    endfunction

    logic [63:0] mem [WORDS];

    rstate_t         rs_q, rs_d;
    logic [31:0]     ra_q;
    logic [3:0]      rid_q;
    logic [7:0]      rlen_q, rcnt_q, rlat_q;
    logic [2:0]      rsize_q;
    logic [1:0]      rburst_q;
    logic            rbad_q;
    logic [31:0]     r_off;
    logic            r_in;
    logic [DEPTH_LOG2-1:0] r_idx;

    wstate_t         ws_q, ws_d;
    logic [31:0]     wa_q;
    logic [3:0]      wid_q;
    logic [7:0]      wlen_q, wcnt_q, wlat_q;
    logic [2:0]      wsize_q;
    logic [1:0]      wburst_q;
    logic            wbad_q;
    logic [1:0]      werr_q, beat_err;
    logic [31:0]     w_off;
    logic            w_in;
    logic            w_en;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign r_off = ra_q - BASE_ADDR;
    assign r_in  = r_off < MEM_BYTES;
    assign r_idx = r_off[OFF_W-1:3];
    assign r_id  = rid_q;

    assign w_off = wa_q - BASE_ADDR;
    assign w_in  = w_off < MEM_BYTES;
    assign w_idx = w_off[OFF_W-1:3];
    assign b_id  = wid_q;

    // Read burst state and address/count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q     <= RIDLE;
            ra_q     <= '0;
            rid_q    <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rlat_q   <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            rbad_q   <= 1'b0;
        end else begin
            rs_q <= rs_d;
            unique case (rs_q)
                RIDLE: if (ar_valid) begin
                    ra_q     <= ar_addr;
                    rid_q    <= ar_id;
                    rlen_q   <= ar_len;
                    rcnt_q   <= ar_len;
                    rlat_q   <= RLAT_LD;
                    rsize_q  <= ar_size;
                    rburst_q <= ar_brust;
                    rbad_q   <= burst_bad(ar_size, ar_len, ar_brust);
                end
                RWAIT: if (rlat_q != 8'd0) rlat_q <= rlat_q - 8'd1;
                RDATA: if (r_ready) begin
                    ra_q   <= next_addr(ra_q, rsize_q, rlen_q, rburst_q);
                    rcnt_q <= rcnt_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Read next state and R channel outputs; data is read combinationally.
    always_comb begin
        rs_d     = rs_q;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        r_last   = 1'b0;
        r_resp   = RESP_OKAY;
        r_data   = '0;
        unique case (rs_q)
            RIDLE: begin
                ar_ready = 1'b1;
                if (ar_valid) rs_d = (RD_LAT == 0) ? RDATA : RWAIT;
            end
            RWAIT: if (rlat_q == 8'd0) rs_d = RDATA;
            RDATA: begin
                r_valid = 1'b1;
                r_last  = (rcnt_q == 8'd0);
                if (!r_in)
                    r_resp = RESP_DECERR;
                else if (rbad_q)
                    r_resp = RESP_SLVERR;
                else
                    r_data = mem[r_idx];
                if (r_ready && (rcnt_q == 8'd0)) rs_d = RIDLE;
            end
            default: rs_d = RIDLE;
        endcase
    end

    // Write burst state, address/count and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ws_q     <= WIDLE;
            wa_q     <= '0;
            wid_q    <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wlat_q   <= '0;
            wsize_q  <= '0;
            wburst_q <= '0;
            wbad_q   <= 1'b0;
            werr_q   <= RESP_OKAY;
        end else begin
            ws_q <= ws_d;
            unique case (ws_q)
                WIDLE: if (aw_valid) begin
                    wa_q     <= aw_addr;
                    wid_q    <= aw_id;
                    wlen_q   <= aw_len;
                    wcnt_q   <= aw_len;
                    wsize_q  <= aw_size;
                    wburst_q <= aw_brust;
                    wbad_q   <= burst_bad(aw_size, aw_len, aw_brust);
                    werr_q   <= burst_bad(aw_size, aw_len, aw_brust)
                                ? RESP_SLVERR : RESP_OKAY;
                end
                WDATA: if (w_valid) begin
                    wa_q   <= next_addr(wa_q, wsize_q, wlen_q, wburst_q);
                    wcnt_q <= wcnt_q - 8'd1;
                    wlat_q <= WLAT_LD;
                    werr_q <= beat_err;
                end
                WWAIT: if (wlat_q != 8'd0) wlat_q <= wlat_q - 8'd1;
                default: ;
            endcase
        end
    end

    // Write next state, W/B outputs and per-beat error folding.
    always_comb begin
        ws_d     = ws_q;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        b_resp   = RESP_OKAY;
        w_en     = 1'b0;
        beat_err = werr_q;
        unique case (ws_q)
            WIDLE: begin
                aw_ready = 1'b1;
                if (aw_valid) ws_d = WDATA;
            end
            WDATA: begin
                w_ready = 1'b1;
                if (!w_in) beat_err = RESP_DECERR;
                if ((w_last != (wcnt_q == 8'd0)) && (beat_err == RESP_OKAY))
                    beat_err = RESP_SLVERR;
                w_en = w_valid && w_in && !wbad_q;
                if (w_valid && (wcnt_q == 8'd0))
                    ws_d = (WR_LAT == 0) ? WRESP : WWAIT;
            end
            WWAIT: if (wlat_q == 8'd0) ws_d = WRESP;
            WRESP: begin
                b_valid = 1'b1;
                b_resp  = werr_q;
                if (b_ready) ws_d = WIDLE;
            end
            default: ws_d = WIDLE;
        endcase
    end

    // Byte-lane array update; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && w_en) begin
            for (int i = 0; i < 8; i++) begin
                if (w_strb[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: vector table of bursts
// plus hand-written backpressure, w_last and reset sequences.
module tb_axi_sram_slave;

    localparam int unsigned RD_LAT = 2;
    localparam int unsigned WR_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_brust;
    logic        ar_valid;
    logic        ar_ready;
    logic [63:0] r_data;
    logic [3:0]  r_id;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] aw_addr;
    logic [3:0]  aw_id;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_brust;
    logic        aw_valid;
    logic        aw_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;

    axi_sram_slave #(
        .BASE_ADDR(32'h8000_0000),
        .DEPTH_LOG2(12),
        .RD_LAT(RD_LAT),
        .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len),
        .ar_size(ar_size), .ar_brust(ar_brust),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_id(r_id), .r_resp(r_resp),
        .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
        .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len),
        .aw_size(aw_size), .aw_brust(aw_brust),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid),
        .b_ready(b_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            nm;
        bit               wr;
        logic [31:0]      addr;
        logic [3:0]       id;
        logic [7:0]       len;
        logic [2:0]       sz;
        logic [1:0]       bu;
        logic [3:0][63:0] d;
        logic [7:0]       strb;
        logic [3:0][63:0] ed;
        logic [3:0][1:0]  er;
        logic [1:0]       eb;
    } vec_t;

    int nvec = 0;
    int nmis = 0;
    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkr(string nm, logic [31:0] a,
        logic [3:0] id, logic [7:0] len, logic [2:0] sz, logic [1:0] bu,
        logic [3:0][63:0] ed, logic [3:0][1:0] er);
        vec_t v;
        v.nm = nm; v.wr = 1'b0; v.addr = a; v.id = id; v.len = len;
        v.sz = sz; v.bu = bu; v.d = '0; v.strb = '0;
        v.ed = ed; v.er = er; v.eb = 2'd0;
        return v;
    endfunction

    function automatic vec_t mkw(string nm, logic [31:0] a,
        logic [3:0] id, logic [7:0] len, logic [2:0] sz, logic [1:0] bu,
        logic [3:0][63:0] d, logic [7:0] strb, logic [1:0] eb);
        vec_t v;
        v.nm = nm; v.wr = 1'b1; v.addr = a; v.id = id; v.len = len;
        v.sz = sz; v.bu = bu; v.d = d; v.strb = strb;
        v.ed = '0; v.er = '0; v.eb = eb;
        return v;
    endfunction

    task automatic ar_send(input string nm, input logic [31:0] a,
        input logic [3:0] id, input logic [7:0] len,
        input logic [2:0] sz, input logic [1:0] bu);
        bit ok;
        ar_addr = a; ar_id = id; ar_len = len;
        ar_size = sz; ar_brust = bu; ar_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ar_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        ar_valid = 1'b0;
        chk({nm, ".ar_hs"}, 64'(ok), 64'd1);
    endtask

    task automatic do_read(input string nm, input logic [31:0] a,
        input logic [3:0] id, input logic [7:0] len,
        input logic [2:0] sz, input logic [1:0] bu,
        input logic [3:0][63:0] ed, input logic [3:0][1:0] er);
        int n;
        ar_send(nm, a, id, len, sz, bu);
        n = 0;
        while (!r_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, ".lat"}, 64'(n), 64'(RD_LAT));
        r_ready = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            chk($sformatf("%s.v%0d", nm, b), 64'(r_valid), 64'd1);
            chk($sformatf("%s.d%0d", nm, b), r_data, ed[b]);
            chk($sformatf("%s.r%0d", nm, b), 64'(r_resp), 64'(er[b]));
            chk($sformatf("%s.l%0d", nm, b), 64'(r_last),
                64'(b == int'(len)));
            chk($sformatf("%s.id%0d", nm, b), 64'(r_id), 64'(id));
            tick();
        end
        r_ready = 1'b0;
        chk({nm, ".end"}, 64'({r_valid, ar_ready}), 64'd1);
    endtask

    task automatic do_write(input string nm, input logic [31:0] a,
        input logic [3:0] id, input logic [7:0] len,
        input logic [2:0] sz, input logic [1:0] bu,
        input logic [3:0][63:0] d, input logic [7:0] strb,
        input int lastb, input logic [1:0] eb);
        bit ok;
        int n;
        aw_addr = a; aw_id = id; aw_len = len;
        aw_size = sz; aw_brust = bu; aw_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (aw_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        aw_valid = 1'b0;
        chk({nm, ".aw_hs"}, 64'(ok), 64'd1);
        for (int b = 0; b <= int'(len); b++) begin
            w_data = d[b]; w_strb = strb;
            w_last = (b == lastb); w_valid = 1'b1;
            n = 0;
            while (!w_ready && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("%s.wr%0d", nm, b), 64'(w_ready), 64'd1);
            tick();
        end
        w_valid = 1'b0;
        w_last = 1'b0;
        chk({nm, ".wdrop"}, 64'(w_ready), 64'd0);
        n = 0;
        while (!b_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, ".blat"}, 64'(n), 64'(WR_LAT));
        chk({nm, ".bresp"}, 64'(b_resp), 64'(eb));
        chk({nm, ".bid"}, 64'(b_id), 64'(id));
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        chk({nm, ".bend"}, 64'({b_valid, aw_ready}), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0][63:0] bp_exp;
        bit pat [4];
        bit stalled;
        logic [63:0] held;
        int got;
        int pi;
        int n;

        rst = 1'b1;
        ar_addr = '0; ar_id = '0; ar_len = '0; ar_size = '0;
        ar_brust = '0; ar_valid = 1'b0; r_ready = 1'b0;
        aw_addr = '0; aw_id = '0; aw_len = '0; aw_size = '0;
        aw_brust = '0; aw_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
        b_ready = 1'b0;
        tick();
        tick();
        chk("rst.ctrl", 64'({ar_ready, aw_ready, r_valid, r_last,
                             w_ready, b_valid}), 64'b110000);
        chk("rst.rdata", r_data, 64'd0);
        chk("rst.ids", 64'({r_id, r_resp, b_id, b_resp}), 64'd0);
        rst = 1'b0;
        tick();

        vt.push_back(mkw("pre", 32'h8000_0000, 4'd1, 8'd3, 3'd3, 2'd1,
            {64'h44, 64'h33, 64'h22, 64'h11}, 8'hFF, 2'd0));
        vt.push_back(mkr("incr4", 32'h8000_0000, 4'd5, 8'd3, 3'd3, 2'd1,
            {64'h44, 64'h33, 64'h22, 64'h11}, '0));
        vt.push_back(mkw("clr1", 32'h8000_0008, 4'd2, 8'd0, 3'd3, 2'd1,
            {64'h0, 64'h0, 64'h0, 64'h0}, 8'hFF, 2'd0));
        vt.push_back(mkw("strb", 32'h8000_0008, 4'd3, 8'd0, 3'd3, 2'd1,
            {64'h0, 64'h0, 64'h0, 64'hAABB_CCDD_EEFF_0011}, 8'h0F, 2'd0));
        vt.push_back(mkr("rdstrb", 32'h8000_0008, 4'd6, 8'd0, 3'd3, 2'd1,
            {64'h0, 64'h0, 64'h0, 64'h0000_0000_EEFF_0011}, '0));
        vt.push_back(mkr("wrap", 32'h8000_0010, 4'd7, 8'd3, 3'd3, 2'd2,
            {64'h0000_0000_EEFF_0011, 64'h11, 64'h44, 64'h33}, '0));
        vt.push_back(mkr("oor_r", 32'h7FFF_FFF8, 4'd8, 8'd1, 3'd3, 2'd1,
            {64'h0, 64'h0, 64'h11, 64'h0}, {2'd0, 2'd0, 2'd0, 2'd3}));
        vt.push_back(mkw("oor_w", 32'h7FFF_FFF8, 4'd9, 8'd1, 3'd3, 2'd1,
            {64'h0, 64'h0, 64'h5555_6666_7777_8888, 64'hDEAD_BEEF_0000_0001},
            8'hFF, 2'd3));
        vt.push_back(mkr("oor_chk", 32'h8000_0000, 4'd10, 8'd0, 3'd3, 2'd1,
            {64'h0, 64'h0, 64'h0, 64'h5555_6666_7777_8888}, '0));
        vt.push_back(mkr("fixed", 32'h8000_0018, 4'd11, 8'd1, 3'd3, 2'd0,
            {64'h0, 64'h0, 64'h44, 64'h44}, '0));
        vt.push_back(mkr("badwrap_r", 32'h8000_0000, 4'd12, 8'd2, 3'd3, 2'd2,
            '0, {2'd0, 2'd2, 2'd2, 2'd2}));
        vt.push_back(mkw("badwrap_w", 32'h8000_0010, 4'd13, 8'd2, 3'd3, 2'd2,
            {64'h0, 64'h3, 64'h2, 64'h1}, 8'hFF, 2'd2));
        vt.push_back(mkr("badwrap_chk", 32'h8000_0010, 4'd14, 8'd0, 3'd3, 2'd1,
            {64'h0, 64'h0, 64'h0, 64'h33}, '0));
        vt.push_back(mkr("narrow", 32'h8000_0010, 4'd15, 8'd1, 3'd2, 2'd1,
            {64'h0, 64'h0, 64'h33, 64'h33}, '0));
        vt.push_back(mkr("badsize", 32'h8000_0000, 4'd4, 8'd0, 3'd4, 2'd1,
            '0, {2'd0, 2'd0, 2'd0, 2'd2}));
        vt.push_back(mkw("top_w", 32'h8000_7FF8, 4'd2, 8'd1, 3'd3, 2'd1,
            {64'h0, 64'h0, 64'hCAFE, 64'h0123_4567_89AB_CDEF}, 8'hFF, 2'd3));
        vt.push_back(mkr("top_r", 32'h8000_7FF8, 4'd3, 8'd1, 3'd3, 2'd1,
            {64'h0, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF},
            {2'd0, 2'd0, 2'd3, 2'd0}));

        foreach (vt[i]) begin
            if (vt[i].wr)
                do_write(vt[i].nm, vt[i].addr, vt[i].id, vt[i].len,
                    vt[i].sz, vt[i].bu, vt[i].d, vt[i].strb,
                    int'(vt[i].len), vt[i].eb);
            else
                do_read(vt[i].nm, vt[i].addr, vt[i].id, vt[i].len,
                    vt[i].sz, vt[i].bu, vt[i].ed, vt[i].er);
        end

        // R backpressure: ready pattern 1,0,0,1 repeated per valid cycle
        bp_exp = {64'h44, 64'h33, 64'h0000_0000_EEFF_0011,
                  64'h5555_6666_7777_8888};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        stalled = 1'b0;
        held = '0;
        got = 0;
        pi = 0;
        ar_send("bp", 32'h8000_0000, 4'd9, 8'd3, 3'd3, 2'd1);
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (r_valid) begin
                if (stalled) chk("bp.hold", r_data, held);
                chk($sformatf("bp.d%0d", got), r_data, bp_exp[got]);
                chk($sformatf("bp.l%0d", got), 64'(r_last), 64'(got == 3));
                r_ready = pat[pi % 4];
                pi++;
                if (r_ready) begin
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = r_data;
                end
            end else begin
                r_ready = 1'b0;
            end
            tick();
        end
        r_ready = 1'b0;
        chk("bp.beats", 64'(got), 64'd4);
        chk("bp.end", 64'({r_valid, ar_ready}), 64'd1);

        // Early w_last: burst still runs three beats, SLVERR reported
        do_write("wlast", 32'h8000_0020, 4'd6, 8'd2, 3'd3, 2'd1,
            {64'h0, 64'hC3, 64'hB2, 64'hA1}, 8'hFF, 1, 2'd2);
        do_read("wlast_chk", 32'h8000_0020, 4'd7, 8'd2, 3'd3, 2'd1,
            {64'h0, 64'hC3, 64'hB2, 64'hA1}, '0);

        // Reset in the middle of a read burst, with r_ready high
        ar_send("rstmid", 32'h8000_0000, 4'd3, 8'd3, 3'd3, 2'd1);
        n = 0;
        while (!r_valid && n < 20) begin
            tick();
            n++;
        end
        chk("rstmid.pre", 64'(r_valid), 64'd1);
        r_ready = 1'b1;
        tick();
        chk("rstmid.beat1", 64'({r_valid, r_last}), 64'b10);
        rst = 1'b1;
        tick();
        chk("rstmid.ctrl", 64'({ar_ready, r_valid, r_last}), 64'b100);
        chk("rstmid.data", r_data, 64'd0);
        rst = 1'b0;
        r_ready = 1'b0;
        tick();
        do_read("post_rst", 32'h8000_0018, 4'd1, 8'd0, 3'd3, 2'd1,
            {64'h0, 64'h0, 64'h0, 64'h44}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
